// File: rtl/verdict_pkt_store.sv
// verdict_pkt_store: store-and-decide packet buffer.
// Ingress AXI-Stream words are buffered in a data FIFO. Per-packet verdicts
// (DROP / PASS / PASS with dst-port override) are queued in a verdict FIFO.
// Packets are released or discarded strictly in arrival order. Pass, drop
// and error statistics are kept alongside.
module verdict_pkt_store #(
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned DATA_DEPTH_LOG2    = 9,
   parameter int unsigned VERDICT_DEPTH_LOG2 = 4,
   parameter int unsigned NEARLY_FULL_MARGIN = 2
) (
   input  logic                              axi_aclk,
   input  logic                              axi_areset,
   // ingress stream
   input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
   input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   // egress stream
   output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   // verdict queue
   input  logic                              verdict_wr_en,
   input  logic [9:0]                        verdict_din,
   output logic                              verdict_nearly_full,
   // statistics
   input  logic                              stats_clear,
   output logic [31:0]                       pass_count,
   output logic [31:0]                       drop_count,
   output logic [15:0]                       err_count
);

   localparam int unsigned STRB_W  = C_AXIS_DATA_WIDTH / 8;
   localparam int unsigned WORD_W  = C_AXIS_DATA_WIDTH + STRB_W + C_AXIS_TUSER_WIDTH + 1;
   localparam int unsigned D_DEPTH = 2 ** DATA_DEPTH_LOG2;
   localparam int unsigned V_DEPTH = 2 ** VERDICT_DEPTH_LOG2;

   localparam logic [DATA_DEPTH_LOG2:0]    D_PTR_ONE = 1;
   localparam logic [VERDICT_DEPTH_LOG2:0] V_PTR_ONE = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DISC = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      ACT_DROP = 2'b00,
      ACT_PASS = 2'b01,
      ACT_OVR  = 2'b10,
      ACT_RSVD = 2'b11
   } action_t;

   // ------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------
   logic [WORD_W-1:0] data_mem [D_DEPTH];
   logic [9:0]        verdict_mem [V_DEPTH];

   // pointers carry one extra wrap bit to tell full from empty
   logic [DATA_DEPTH_LOG2:0]    d_wr_ptr_q, d_wr_ptr_d;
   logic [DATA_DEPTH_LOG2:0]    d_rd_ptr_q, d_rd_ptr_d;
   logic [VERDICT_DEPTH_LOG2:0] v_wr_ptr_q, v_wr_ptr_d;
   logic [VERDICT_DEPTH_LOG2:0] v_rd_ptr_q, v_rd_ptr_d;

   // FSM and latched verdict
   state_t     state_q, state_d;
   logic       ovr_q, ovr_d;
   logic [7:0] dst_q, dst_d;
   logic       first_q, first_d;

   // ingress enable: held low through reset, high from the first clock after
   logic       rdy_q, rdy_d;

   // statistics
   logic [31:0] pass_q, pass_d;
   logic [31:0] drop_q, drop_d;
   logic [15:0] err_q, err_d;

   // ------------------------------------------------------------------
   // Combinational status
   // ------------------------------------------------------------------
   logic                            d_empty, d_full, d_push, d_pop;
   logic                            v_empty, v_full, v_push, v_pop, v_ovf;
   logic [VERDICT_DEPTH_LOG2:0]     v_used;
   int unsigned                     v_free;
   logic [WORD_W-1:0]               head_word;
   logic [C_AXIS_DATA_WIDTH-1:0]    head_data;
   logic [STRB_W-1:0]               head_strb;
   logic [C_AXIS_TUSER_WIDTH-1:0]   head_user;
   logic                            head_last;
   logic [9:0]                      v_head;
   action_t                         v_act;
   logic                            pass_inc, drop_inc, rsvd_err;
   logic [1:0]                      err_inc;
   logic [16:0]                     err_sum;

   // FIFO status flags, ingress handshake and head-of-queue decode
   always_comb begin
      d_empty = (d_wr_ptr_q == d_rd_ptr_q);
      d_full  = (d_wr_ptr_q[DATA_DEPTH_LOG2] != d_rd_ptr_q[DATA_DEPTH_LOG2]) &&
                (d_wr_ptr_q[DATA_DEPTH_LOG2-1:0] == d_rd_ptr_q[DATA_DEPTH_LOG2-1:0]);
      v_empty = (v_wr_ptr_q == v_rd_ptr_q);
      v_full  = (v_wr_ptr_q[VERDICT_DEPTH_LOG2] != v_rd_ptr_q[VERDICT_DEPTH_LOG2]) &&
                (v_wr_ptr_q[VERDICT_DEPTH_LOG2-1:0] == v_rd_ptr_q[VERDICT_DEPTH_LOG2-1:0]);

      v_used  = v_wr_ptr_q - v_rd_ptr_q;
      v_free  = V_DEPTH - 32'(v_used);
      verdict_nearly_full = (v_free <= NEARLY_FULL_MARGIN);

      s_axis_tready = rdy_q & ~d_full;
      d_push        = s_axis_tvalid & s_axis_tready;
      v_push        = verdict_wr_en & ~v_full;
      v_ovf         = verdict_wr_en & v_full;

      head_word = data_mem[d_rd_ptr_q[DATA_DEPTH_LOG2-1:0]];
      head_data = head_word[C_AXIS_DATA_WIDTH-1:0];
      head_strb = head_word[C_AXIS_DATA_WIDTH +: STRB_W];
      head_user = head_word[C_AXIS_DATA_WIDTH + STRB_W +: C_AXIS_TUSER_WIDTH];
      head_last = head_word[WORD_W-1];

      v_head = verdict_mem[v_rd_ptr_q[VERDICT_DEPTH_LOG2-1:0]];
      v_act  = action_t'(v_head[1:0]);
   end

   // Packet FSM: verdict pop, forward/discard of buffered words
   always_comb begin
      state_d       = state_q;
      ovr_d         = ovr_q;
      dst_d         = dst_q;
      first_d       = first_q;
      v_pop         = 1'b0;
      d_pop         = 1'b0;
      m_axis_tvalid = 1'b0;
      pass_inc      = 1'b0;
      drop_inc      = 1'b0;
      rsvd_err      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (!v_empty && !d_empty) begin
               v_pop   = 1'b1;
               dst_d   = v_head[9:2];
               ovr_d   = (v_act == ACT_OVR);
               first_d = 1'b1;
               unique case (v_act)
                  ACT_PASS, ACT_OVR: state_d = ST_FWD;
                  ACT_RSVD: begin
                     rsvd_err = 1'b1;
                     state_d  = ST_DISC;
                  end
                  default: state_d = ST_DISC;
               endcase
            end
         end
         ST_FWD: begin
            m_axis_tvalid = ~d_empty;
            if (m_axis_tvalid && m_axis_tready) begin
               d_pop   = 1'b1;
               first_d = 1'b0;
               if (head_last) begin
                  pass_inc = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         ST_DISC: begin
            if (!d_empty) begin
               d_pop = 1'b1;
               if (head_last) begin
                  drop_inc = 1'b1;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Egress data: head word, with dst bitmap overridden on the first override beat
   always_comb begin
      m_axis_tdata = head_data;
      m_axis_tstrb = head_strb;
      m_axis_tlast = head_last;
      m_axis_tuser = head_user;
      if (state_q == ST_FWD && ovr_q && first_q) begin
         m_axis_tuser[31:24] = dst_q;
      end
   end

   // Pointer and statistics next-state; clear takes priority over increments
   always_comb begin
      d_wr_ptr_d = d_push ? d_wr_ptr_q + D_PTR_ONE : d_wr_ptr_q;
      d_rd_ptr_d = d_pop  ? d_rd_ptr_q + D_PTR_ONE : d_rd_ptr_q;
      v_wr_ptr_d = v_push ? v_wr_ptr_q + V_PTR_ONE : v_wr_ptr_q;
      v_rd_ptr_d = v_pop  ? v_rd_ptr_q + V_PTR_ONE : v_rd_ptr_q;
      rdy_d      = 1'b1;

      // a reserved-action pop and a verdict overflow can land in the same cycle
      err_inc = {1'b0, rsvd_err} + {1'b0, v_ovf};
      err_sum = {1'b0, err_q} + {15'd0, err_inc};

      if (stats_clear) begin
         pass_d = '0;
         drop_d = '0;
         err_d  = '0;
      end else begin
         pass_d = pass_q + 32'(pass_inc);
         drop_d = drop_q + 32'(drop_inc);
         err_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
      end

      pass_count = pass_q;
      drop_count = drop_q;
      err_count  = err_q;
   end

   // Data FIFO storage write
   always_ff @(posedge axi_aclk) begin
      if (d_push) begin
         data_mem[d_wr_ptr_q[DATA_DEPTH_LOG2-1:0]] <=
            {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};
      end
   end

   // Verdict FIFO storage write
   always_ff @(posedge axi_aclk) begin
      if (v_push) begin
         verdict_mem[v_wr_ptr_q[VERDICT_DEPTH_LOG2-1:0]] <= verdict_din;
      end
   end

   // State registers; reset flushes both queues and any partial packet
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         d_wr_ptr_q <= '0;
         d_rd_ptr_q <= '0;
         v_wr_ptr_q <= '0;
         v_rd_ptr_q <= '0;
         state_q    <= ST_IDLE;
         ovr_q      <= 1'b0;
         dst_q      <= '0;
         first_q    <= 1'b0;
         rdy_q      <= 1'b0;
         pass_q     <= '0;
         drop_q     <= '0;
         err_q      <= '0;
      end else begin
         d_wr_ptr_q <= d_wr_ptr_d;
         d_rd_ptr_q <= d_rd_ptr_d;
         v_wr_ptr_q <= v_wr_ptr_d;
         v_rd_ptr_q <= v_rd_ptr_d;
         state_q    <= state_d;
         ovr_q      <= ovr_d;
         dst_q      <= dst_d;
         first_q    <= first_d;
         rdy_q      <= rdy_d;
         pass_q     <= pass_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_verdict_pkt_store.sv
// tb_verdict_pkt_store: directed bench for verdict_pkt_store.
module tb_verdict_pkt_store;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic [SW-1:0] s_tstrb = '0;
   logic [UW-1:0] s_tuser = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic          s_tlast = 1'b0;
   logic [DW-1:0] m_tdata;
   logic [SW-1:0] m_tstrb;
   logic [UW-1:0] m_tuser;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic          m_tlast;
   logic          v_wr = 1'b0;
   logic [9:0]    v_din = '0;
   logic          v_nf;
   logic          s_clr = 1'b0;
   logic [31:0]   pass_cnt, drop_cnt;
   logic [15:0]   err_cnt;

   always #5 clk = ~clk;

   verdict_pkt_store #(
      .C_AXIS_DATA_WIDTH (DW),
      .C_AXIS_TUSER_WIDTH(UW),
      .DATA_DEPTH_LOG2   (9),
      .VERDICT_DEPTH_LOG2(4),
      .NEARLY_FULL_MARGIN(2)
   ) dut (
      .axi_aclk           (clk),
      .axi_areset         (rst),
      .s_axis_tdata       (s_tdata),
      .s_axis_tstrb       (s_tstrb),
      .s_axis_tuser       (s_tuser),
      .s_axis_tvalid      (s_tvalid),
      .s_axis_tready      (s_tready),
      .s_axis_tlast       (s_tlast),
      .m_axis_tdata       (m_tdata),
      .m_axis_tstrb       (m_tstrb),
      .m_axis_tuser       (m_tuser),
      .m_axis_tvalid      (m_tvalid),
      .m_axis_tready      (m_tready),
      .m_axis_tlast       (m_tlast),
      .verdict_wr_en      (v_wr),
      .verdict_din        (v_din),
      .verdict_nearly_full(v_nf),
      .stats_clear        (s_clr),
      .pass_count         (pass_cnt),
      .drop_count         (drop_cnt),
      .err_count          (err_cnt)
   );

   typedef struct packed {
      logic          l;
      logic [UW-1:0] u;
      logic [SW-1:0] s;
      logic [DW-1:0] d;
   } beat_t;

   beat_t got_q[$];
   beat_t exp_q[$];
   int    n_chk = 0;
   int    n_bad = 0;

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic beat_t mk(input int pid, input int w, input int n);
      beat_t b;
      b.d = {8{16'(pid), 16'(w)}};
      b.s = (w == n - 1) ? 32'h00FF_FFFF : 32'hFFFF_FFFF;
      b.u = {96'h0, 8'hA5, 8'(pid), 16'(w)};
      b.l = (w == n - 1);
      return b;
   endfunction

   // egress monitor: records beats and checks hold-while-stalled
   beat_t cur, held;
   logic  stall_seen = 1'b0;
   always @(negedge clk) begin
      cur = {m_tlast, m_tuser, m_tstrb, m_tdata};
      if (rst) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            chk("stall_valid", 512'(m_tvalid), 512'(1));
            chk("stall_hold", 512'(cur), 512'(held));
         end
         if (m_tvalid && m_tready) got_q.push_back(cur);
         stall_seen = m_tvalid && !m_tready;
         held = cur;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_v(input logic [9:0] din);
      v_wr  = 1'b1;
      v_din = din;
      tick();
      v_wr  = 1'b0;
   endtask

   // sends words 0..stop-1 of an n-word packet
   task automatic send_pkt(input int pid, input int n, input int stop);
      beat_t b;
      int    t;
      for (int w = 0; w < stop; w++) begin
         b        = mk(pid, w, n);
         s_tdata  = b.d;
         s_tstrb  = b.s;
         s_tuser  = b.u;
         s_tlast  = b.l;
         s_tvalid = 1'b1;
         t = 0;
         while (!s_tready && t < 200) begin
            tick();
            t++;
         end
         if (t >= 200) chk("in_ready", 512'(s_tready), 512'(1));
         tick();
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_cnt(input string tag, input int sel, input int exp);
      int t = 0;
      while (((sel == 0) ? pass_cnt : drop_cnt) != 32'(exp) && t < 300) begin
         tick();
         t++;
      end
      chk(tag, 512'((sel == 0) ? pass_cnt : drop_cnt), 512'(exp));
   endtask

   task automatic check_cnts(input string tag, input int p, input int d, input int e);
      chk({tag, "_pass"}, 512'(pass_cnt), 512'(p));
      chk({tag, "_drop"}, 512'(drop_cnt), 512'(d));
      chk({tag, "_err"},  512'(err_cnt),  512'(e));
   endtask

   task automatic check_beats(input string tag);
      chk({tag, "_nbeats"}, 512'(got_q.size()), 512'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk(tag, 512'(got_q[i]), 512'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic clear_stats();
      s_clr = 1'b1;
      tick();
      s_clr = 1'b0;
      check_cnts("clr", 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_s_tready", 512'(s_tready), 512'(0));
      chk("rst_m_tvalid", 512'(m_tvalid), 512'(0));
      chk("rst_nearly_full", 512'(v_nf), 512'(0));
      check_cnts("rst", 0, 0, 0);
      rst = 1'b0;
      got_q.delete();
      tick();
      chk("rel_s_tready", 512'(s_tready), 512'(1));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      beat_t b;
      tick();
      do_reset();

      // 1: plain PASS, dst field must not be applied
      push_v({8'h5A, 2'b01});
      for (int w = 0; w < 3; w++) exp_q.push_back(mk(1, w, 3));
      send_pkt(1, 3, 3);
      wait_cnt("t1_pass", 0, 1);
      check_beats("t1_beat");
      check_cnts("t1", 1, 0, 0);
      clear_stats();

      // 2: PASS with override, only first beat rewritten
      push_v({8'h04, 2'b10});
      b = mk(2, 0, 2);
      b.u[31:24] = 8'h04;
      exp_q.push_back(b);
      exp_q.push_back(mk(2, 1, 2));
      send_pkt(2, 2, 2);
      wait_cnt("t2_pass", 0, 1);
      check_beats("t2_beat");
      clear_stats();

      // 3: DROP, PASS, reserved in sequence
      push_v({8'h11, 2'b00});
      push_v({8'h22, 2'b01});
      push_v({8'h33, 2'b11});
      for (int w = 0; w < 3; w++) exp_q.push_back(mk(4, w, 3));
      send_pkt(3, 2, 2);
      send_pkt(4, 3, 3);
      send_pkt(5, 1, 1);
      wait_cnt("t3_drop", 1, 2);
      check_beats("t3_beat");
      check_cnts("t3", 1, 2, 1);
      clear_stats();

      // 4: verdict FIFO fill, nearly-full threshold, overflow
      for (int k = 1; k <= 16; k++) begin
         push_v({8'h00, 2'b01});
         if (k == 13) chk("t4_nf_13", 512'(v_nf), 512'(0));
         if (k == 14) chk("t4_nf_14", 512'(v_nf), 512'(1));
      end
      chk("t4_err_full", 512'(err_cnt), 512'(0));
      push_v({8'h00, 2'b01});
      chk("t4_err_ovf", 512'(err_cnt), 512'(1));
      chk("t4_nf_17", 512'(v_nf), 512'(1));
      do_reset();

      // 5: egress stalls with tready 1010...
      push_v({8'h00, 2'b01});
      for (int w = 0; w < 4; w++) exp_q.push_back(mk(6, w, 4));
      fork
         send_pkt(6, 4, 4);
         begin
            for (int i = 0; i < 30; i++) begin
               m_tready = (i % 2 == 0);
               tick();
            end
            m_tready = 1'b1;
         end
      join
      wait_cnt("t5_pass", 0, 1);
      check_beats("t5_beat");

      // 6: reset in the middle of a 5-word packet
      push_v({8'h00, 2'b01});
      send_pkt(8, 5, 2);
      do_reset();
      push_v({8'h00, 2'b01});
      for (int w = 0; w < 2; w++) exp_q.push_back(mk(9, w, 2));
      send_pkt(9, 2, 2);
      wait_cnt("t6_pass", 0, 1);
      repeat (3) tick();
      check_beats("t6_beat");
      check_cnts("t6", 1, 0, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
